// File: rtl/axicb_resp_router.sv
// Response return-path router for one crossbar slave port and one response
// channel (B or R). Every accepted grant records the granted requester in an
// in-order tracking FIFO; response bursts from the slave are steered to the
// requester at the FIFO head, and the head is retired on the last beat.
module axicb_resp_router #(
  parameter int REQ_NB = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  input  logic                    grant_valid,
  input  logic [REQ_NB-1:0]       grant,
  output logic                    grant_ready,
  input  logic                    rsp_valid,
  output logic                    rsp_ready,
  input  logic                    rsp_last,
  input  logic [DATA_W-1:0]       rsp_data,
  output logic [REQ_NB-1:0]       m_rsp_valid,
  input  logic [REQ_NB-1:0]       m_rsp_ready,
  output logic [DATA_W-1:0]       m_rsp_data,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic                    err_orphan
);

  localparam int IDX_W = $clog2(REQ_NB);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] head;
  logic             nonempty;
  logic             push;
  logic             pop;

  // Encode the lowest set grant bit; a non-one-hot grant collapses to its LSB.
  always_comb begin
    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    grant_idx = '0;
    for (int i = REQ_NB - 1; i >= 0; i--) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  // Readiness depends on the registered count only, so a pop never frees a
  // slot for a push in the same cycle (no ready-to-ready combinational path).
  assign nonempty    = (count != '0);
  assign grant_ready = (count < CNT_W'(DEPTH));
  assign push        = grant_valid && grant_ready && (|grant);
  assign head        = mem[rd_ptr];
  assign rsp_ready   = nonempty && m_rsp_ready[head];
  assign pop         = rsp_valid && rsp_ready && rsp_last;
  assign m_rsp_data  = rsp_data;
  assign outstanding = count;

  // Steer the slave's valid to the head requester only; an empty FIFO routes nothing.
  always_comb begin
    m_rsp_valid = '0;
    if (rsp_valid && nonempty) m_rsp_valid[head] = 1'b1;
  end

  // Pointer, occupancy and sticky orphan-error state; srst outranks push/pop.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else if (srst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rsp_valid && !nonempty) err_orphan <= 1'b1;
    end
  end

  // Tracking storage; entries are only ever read behind a nonzero count.
  always_ff @(posedge aclk) begin
    // NOTE: the storage array has no reset; the pointers and count alone define which entries are live.
    if (push && !srst) mem[wr_ptr] <= grant_idx;
  end

endmodule

// File: tb/tb_axicb_resp_router.sv
// Self-checking bench for axicb_resp_router: directed scenarios followed by a
// randomized phase. A reference model keeps the expected requester order in a
// queue; a monitor on the falling edge compares every DUT output against it.
module tb_axicb_resp_router;

  localparam int REQ_NB = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic                   aclk = 1'b0;
  logic                   aresetn;
  logic                   srst;
  logic                   grant_valid;
  logic [REQ_NB-1:0]      grant;
  logic                   grant_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_last;
  logic [DATA_W-1:0]      rsp_data;
  logic [REQ_NB-1:0]      m_rsp_valid;
  logic [REQ_NB-1:0]      m_rsp_ready;
  logic [DATA_W-1:0]      m_rsp_data;
  logic [$clog2(DEPTH):0] outstanding;
  logic                   err_orphan;

  int checks = 0;
  int errors = 0;
  int exp_q[$];        // expected requester order, head = next to be served
  bit orphan_m = 1'b0; // expected sticky orphan flag
  int neg_size = 0;    // model occupancy seen before this cycle's edge
  bit beat_acc = 1'b0; // slave beat was accepted this cycle

  axicb_resp_router #(.REQ_NB(REQ_NB), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .grant_valid(grant_valid), .grant(grant), .grant_ready(grant_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_last(rsp_last),
    .rsp_data(rsp_data), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_data(m_rsp_data), .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int lsb_idx(input logic [REQ_NB-1:0] g);
    for (int i = 0; i < REQ_NB; i++) if (g[i]) return i;
    return 0;
  endfunction

  // Reference model: a grant is recorded when there was room before the edge.
  always @(posedge aclk) begin
    if (!aresetn || srst) begin
      exp_q.delete();
      orphan_m = 1'b0;
    end else begin
      if (rsp_valid && neg_size == 0) orphan_m = 1'b1;
      if (grant_valid && neg_size < DEPTH && grant != '0) exp_q.push_back(lsb_idx(grant));
    end
  end

  // Monitor: compare all outputs mid-cycle and retire the head on an accepted last beat.
  always @(negedge aclk) begin
    int sz;
    int hd;
    logic [REQ_NB-1:0] ev;
    sz = exp_q.size();
    hd = (sz > 0) ? exp_q[0] : 0;
    ev = '0;
    if (rsp_valid && sz > 0) ev[hd] = 1'b1;
    check("grant_ready", 32'(grant_ready), 32'(sz < DEPTH));
    check("outstanding", 32'(outstanding), 32'(sz));
    check("m_rsp_valid", 32'(m_rsp_valid), 32'(ev));
    check("rsp_ready", 32'(rsp_ready), 32'(sz > 0 && m_rsp_ready[hd]));
    check("err_orphan", 32'(err_orphan), 32'(orphan_m));
    check("m_rsp_data", 32'(m_rsp_data), 32'(rsp_data));
    beat_acc = rsp_valid && sz > 0 && m_rsp_ready[hd];
    if (beat_acc && rsp_last) void'(exp_q.pop_front());
    neg_size = sz;
  end

  // Apply one cycle of stimulus just after the rising edge; a stalled beat keeps its payload.
  task automatic drive(input logic gv, input logic [REQ_NB-1:0] g, input logic rv,
                       input logic rl, input logic [REQ_NB-1:0] mr);
    @(posedge aclk);
    #1;
    if (!(rsp_valid && !beat_acc)) rsp_data = DATA_W'($urandom);
    grant_valid = gv;
    grant       = g;
    rsp_valid   = rv;
    rsp_last    = rl;
    m_rsp_ready = mr;
  endtask

  task automatic mid;
    @(negedge aclk);
    #1;
  endtask

  initial begin
    aresetn = 1'b0; srst = 1'b0; grant_valid = 1'b0; grant = '0;
    rsp_valid = 1'b0; rsp_last = 1'b0; rsp_data = '0; m_rsp_ready = '0;
    mid;
    check("rst_grant_ready", 32'(grant_ready), 32'd1);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    @(posedge aclk); #2 aresetn = 1'b1;

    // In-order single-beat responses.
    drive(1, 4'b0001, 0, 0, 4'b1111);
    drive(1, 4'b0100, 0, 0, 4'b1111);
    drive(1, 4'b1000, 0, 0, 4'b1111);
    drive(0, 4'b0000, 1, 1, 4'b1111); mid;
    check("t1_valid0", 32'(m_rsp_valid), 32'b0001); check("t1_out3", 32'(outstanding), 32'd3);
    drive(0, 4'b0000, 1, 1, 4'b1111); mid;
    check("t1_valid1", 32'(m_rsp_valid), 32'b0100); check("t1_out2", 32'(outstanding), 32'd2);
    drive(0, 4'b0000, 1, 1, 4'b1111); mid;
    check("t1_valid2", 32'(m_rsp_valid), 32'b1000); check("t1_out1", 32'(outstanding), 32'd1);
    drive(0, 4'b0000, 0, 0, 4'b1111); mid;
    check("t1_out0", 32'(outstanding), 32'd0);

    // Fill to full, refused grant, pop with simultaneous grant.
    for (int i = 0; i < 4; i++) drive(1, REQ_NB'(1 << i), 0, 0, 4'b0000);
    drive(1, 4'b0010, 0, 0, 4'b0000); mid;
    check("t2_full_ready", 32'(grant_ready), 32'd0); check("t2_full_out", 32'(outstanding), 32'd4);
    drive(1, 4'b0010, 1, 1, 4'b1111); mid;
    check("t2_popgrant_ready", 32'(grant_ready), 32'd0);
    drive(0, 4'b0000, 0, 0, 4'b1111); mid;
    check("t2_after_out", 32'(outstanding), 32'd3); check("t2_after_ready", 32'(grant_ready), 32'd1);
    repeat (3) drive(0, 4'b0000, 1, 1, 4'b1111);
    drive(0, 4'b0000, 0, 0, 4'b1111); mid;
    check("t2_drained", 32'(outstanding), 32'd0);

    // Burst lock on requester 2 with a backpressure bubble.
    drive(1, 4'b0100, 0, 0, 4'b1111);
    drive(0, 4'b0000, 1, 0, 4'b0100); mid; check("t3_b1_ready", 32'(rsp_ready), 32'd1);
    drive(0, 4'b0000, 1, 0, 4'b0000); mid; check("t3_b2_stall", 32'(rsp_ready), 32'd0);
    check("t3_b2_valid", 32'(m_rsp_valid), 32'b0100);
    drive(0, 4'b0000, 1, 0, 4'b0100);
    drive(0, 4'b0000, 1, 0, 4'b0100); mid; check("t3_b3_out", 32'(outstanding), 32'd1);
    drive(0, 4'b0000, 1, 1, 4'b0100); mid; check("t3_b4_valid", 32'(m_rsp_valid), 32'b0100);
    drive(0, 4'b0000, 0, 0, 4'b1111); mid; check("t3_popped", 32'(outstanding), 32'd0);

    // Orphan response, then a late grant picks it up one cycle after the push.
    drive(0, 4'b0000, 1, 1, 4'b1111); mid;
    check("t4_orphan_ready", 32'(rsp_ready), 32'd0); check("t4_orphan_valid", 32'(m_rsp_valid), 32'd0);
    drive(1, 4'b0010, 1, 1, 4'b1111); mid;
    check("t4_err_set", 32'(err_orphan), 32'd1); check("t4_push_cycle", 32'(rsp_ready), 32'd0);
    drive(0, 4'b0000, 1, 1, 4'b1111); mid;
    check("t4_routed", 32'(m_rsp_valid), 32'b0010);
    drive(0, 4'b0000, 0, 0, 4'b1111); mid;
    check("t4_err_sticky", 32'(err_orphan), 32'd1);
    srst = 1'b1;
    drive(0, 4'b0000, 0, 0, 4'b1111); srst = 1'b0; mid;
    check("t4_err_srst", 32'(err_orphan), 32'd0);

    // Simultaneous push and pop across the pointer wrap.
    drive(1, 4'b0001, 0, 0, 4'b1111);
    for (int k = 1; k <= 10; k++) begin
      drive(1, REQ_NB'(1 << (k % 4)), 1, 1, 4'b1111); mid;
      check("t5_out1", 32'(outstanding), 32'd1);
    end
    drive(0, 4'b0000, 1, 1, 4'b1111);
    drive(0, 4'b0000, 0, 0, 4'b1111);

    // Asynchronous reset in the middle of a burst.
    drive(1, 4'b0010, 0, 0, 4'b1111);
    drive(1, 4'b0100, 0, 0, 4'b1111);
    drive(1, 4'b1000, 0, 0, 4'b1111);
    drive(0, 4'b0000, 1, 0, 4'b1111);
    #1 aresetn = 1'b0; rsp_valid = 1'b0; exp_q.delete(); orphan_m = 1'b0;
    #1;
    check("t6_arst_valid", 32'(m_rsp_valid), 32'd0); check("t6_arst_rready", 32'(rsp_ready), 32'd0);
    check("t6_arst_gready", 32'(grant_ready), 32'd1); check("t6_arst_out", 32'(outstanding), 32'd0);
    #1 aresetn = 1'b1;

    // Synchronous reset in the middle of a burst.
    drive(1, 4'b0010, 0, 0, 4'b1111);
    drive(1, 4'b0100, 0, 0, 4'b1111);
    drive(1, 4'b1000, 0, 0, 4'b1111);
    drive(0, 4'b0000, 1, 0, 4'b1111); srst = 1'b1; mid;
    check("t6_srst_pre", 32'(outstanding), 32'd3);
    drive(0, 4'b0000, 0, 0, 4'b1111); srst = 1'b0; mid;
    check("t6_srst_out", 32'(outstanding), 32'd0); check("t6_srst_valid", 32'(m_rsp_valid), 32'd0);
    check("t6_srst_gready", 32'(grant_ready), 32'd1);

    // Randomized traffic; the monitor checks every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [REQ_NB-1:0] g;
      logic rv, rl;
      r = $urandom_range(0, 9);
      if (r < 7)       g = REQ_NB'(1 << $urandom_range(0, REQ_NB - 1));
      else if (r == 7) g = '0;
      else             g = REQ_NB'($urandom);
      if (rsp_valid && !beat_acc) begin
        rv = rsp_valid; rl = rsp_last;
      end else begin
        rv = 1'($urandom_range(0, 1)); rl = ($urandom_range(0, 2) == 0);
      end
      drive(($urandom_range(0, 2) == 0), g, rv, rl, REQ_NB'($urandom | $urandom));
      srst = ($urandom_range(0, 299) == 0);
    end

    // Drain remaining entries with single-beat responses.
    srst = 1'b0;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) drive(0, 4'b0000, 1, 1, 4'b1111);
    drive(0, 4'b0000, 0, 0, 4'b1111); mid;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_out", 32'(outstanding), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
